pv_table_loader: RTL
====================

Name: pv_table_loader

Overview:
- Writer side of the PV-table control word consumed by the move evaluators' PV match logic.
- Takes a principal-variation line as a start command plus a valid/ready stream of UCI moves.
- Emits one `pv_ctrl_out` table-write word per ply: plies 0..len-1 as valid entries, the remaining plies up to MAX_DEPTH-1 invalidated.
- Sits between the host/control register block and the `pv_ctrl_in` bus fanned out to all evaluators.

Parameters:
- UCI_WIDTH, 16, width of one UCI move encoding.
- MAX_DEPTH_LOG2, 5, log2 of PV table depth. MAX_DEPTH = 2**MAX_DEPTH_LOG2 and must equal `` `MAX_DEPTH ``. UCI_WIDTH + MAX_DEPTH_LOG2 + 1 <= 31 (elaboration-time check).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- start  in  1  one-cycle load command, sampled only in IDLE.
- pv_len  in  MAX_DEPTH_LOG2+1  number of valid moves in the line, sampled with start.
- uci_in  in  UCI_WIDTH  next PV move, ply order.
- uci_valid  in  1  uci_in valid.
- uci_ready  out  1  move accepted when uci_valid && uci_ready.
- pv_ctrl_out  out  32  table-write word:
  - [31] write strobe.
  - [UCI_WIDTH+MAX_DEPTH_LOG2] entry valid.
  - [UCI_WIDTH+:MAX_DEPTH_LOG2] ply.
  - [UCI_WIDTH-1:0] entry.
  - All other bits are 0.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when all MAX_DEPTH plies have been written.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low. In reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - pv_ctrl_out=0, uci_ready=0, busy=0, done=0.
  - Ply counter and length register are cleared.
- Reset mid-load aborts immediately. No further write strobes are issued. A partially written table is the host's concern.
- All outputs are registered, except uci_ready, which is decoded from the state register.
- States:
  - IDLE: uci_ready=0, busy=0.
    - start=1 → latch len_r = min(pv_len, MAX_DEPTH). Clear ply to 0.
    - Next state is LOAD if len_r>0, else FILL.
    - start is ignored in every other state.
  - LOAD: uci_ready=1, busy=1.
    - On accept, the next cycle has pv_ctrl_out = {1, zeros, 1, ply, uci_in}, and ply increments.
    - After the accept with ply==len_r-1: go to FILL if len_r<MAX_DEPTH, else go to DONE.
    - uci_valid=0 → no strobe that cycle (pv_ctrl_out=0). Stalls are unbounded.
  - FILL: uci_ready=0, busy=1.
    - Each cycle, the next cycle has pv_ctrl_out = {1, zeros, 0, ply, 0}, and ply increments.
    - After ply==MAX_DEPTH-1 is issued → DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next state is IDLE.
- pv_ctrl_out is 0 on every cycle without a strobe, so there is exactly one strobe per ply per load.
- Timing with start at cycle 0, no stalls:
  - First strobe at cycle 2.
  - Last strobe (ply MAX_DEPTH-1) at cycle MAX_DEPTH+1.
  - done at cycle MAX_DEPTH+2.
  - start is accepted again from cycle MAX_DEPTH+3.
- busy is high from cycle 1 through the cycle of the last strobe.
- The ply counter is MAX_DEPTH_LOG2+1 bits wide and never wraps. Plies are issued strictly ascending 0..MAX_DEPTH-1.
- pv_len > MAX_DEPTH is clamped to MAX_DEPTH, so no FILL phase occurs. Extra stream moves are left unconsumed.
- A move presented with uci_valid outside LOAD is not consumed.

Test Plan:
1. Defaults, start with pv_len=3, moves 0x1234, 0x0A0B, 0x00FF streamed back-to-back:
   - Cycles 2-4: strobes to plies 0-2, valid=1, entries as sent.
   - Cycles 5-33: plies 3-31, valid=0, entry 0.
   - done=1 at cycle 34 only, busy=0 at 34.
2. pv_len=0 → 32 invalidating strobes to plies 0..31 in cycles 2-33. uci_ready is never 1.
3. pv_len=40 with 32 moves streamed → 32 valid strobes to plies 0-31, no FILL phase. The 33rd move is not accepted (uci_ready=0).
4. pv_len=2, uci_valid low for 5 cycles between the two moves:
   - No strobes during the stall.
   - Ply 1 is written the cycle after the second accept.
   - Total strobes = 32, no duplicate ply.
5. start re-asserted while busy → ignored: strobe sequence unchanged, single done pulse.
6. reset_n=0 for one cycle during FILL at ply 10:
   - Next cycle: pv_ctrl_out=0, busy=0, no done pulse.
   - A subsequent start with pv_len=1 completes normally.

Source files
------------

// File: rtl/pv_table_loader_if.sv
// Host-side bundle for pv_table_loader: load command, UCI move stream and the
// registered table-write word fanned out to the evaluators' pv_ctrl_in bus.
interface pv_table_loader_if #(
   parameter int UCI_WIDTH      = 16,
   parameter int MAX_DEPTH_LOG2 = 5
);
   logic                      start;
   logic [MAX_DEPTH_LOG2:0]   pv_len;
   logic [UCI_WIDTH-1:0]      uci_in;
   logic                      uci_valid;
   logic                      uci_ready;
   logic [31:0]               pv_ctrl_out;
   logic                      busy;
   logic                      done;

   modport master (
      output start, pv_len, uci_in, uci_valid,
      input  uci_ready, pv_ctrl_out, busy, done
   );

   modport slave (
      input  start, pv_len, uci_in, uci_valid,
      output uci_ready, pv_ctrl_out, busy, done
   );
endinterface

// File: rtl/pv_table_loader.sv
// Writes a PV line into the evaluators' PV table: one write word per ply, the
// first len plies from the move stream, the rest invalidated, then a done pulse.
`ifndef MAX_DEPTH
`define MAX_DEPTH 32
`endif
module pv_table_loader #(
   parameter int UCI_WIDTH      = 16,
   parameter int MAX_DEPTH_LOG2 = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   pv_table_loader_if.slave bus
);
   localparam int            MAX_DEPTH = 2 ** MAX_DEPTH_LOG2;
   localparam int            CW        = MAX_DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_DEPTH);
   localparam logic [CW-1:0] LAST_PLY  = CW'(MAX_DEPTH - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);

   if (MAX_DEPTH != `MAX_DEPTH) begin : g_depth_chk
      $error("pv_table_loader: 2**MAX_DEPTH_LOG2 must equal MAX_DEPTH");
   end
   if (UCI_WIDTH + MAX_DEPTH_LOG2 + 1 > 31) begin : g_width_chk
      $error("pv_table_loader: entry, ply and valid fields overlap the write strobe");
   end

   typedef enum logic [1:0] {IDLE, LOAD, FILL, DONE} state_e;

   state_e        state_q;
   logic [CW-1:0] ply_q;
   logic [CW-1:0] len_q;
   logic [31:0]   ctrl_q;
   logic          busy_q;
   logic          done_q;
   logic [CW-1:0] ply_d;
   logic [CW-1:0] len_d;

   assign ply_d = ply_q + ONE;
   assign len_d = (bus.pv_len > MAX_CNT) ? MAX_CNT : bus.pv_len;

   function automatic logic [31:0] ctrl_word(input logic                      vld,
                                             input logic [MAX_DEPTH_LOG2-1:0] ply,
                                             input logic [UCI_WIDTH-1:0]      entry);
      logic [31:0] w;
      w                              = '0;
      w[31]                          = 1'b1;
      w[UCI_WIDTH+MAX_DEPTH_LOG2]    = vld;
      w[UCI_WIDTH+:MAX_DEPTH_LOG2]   = ply;
      w[UCI_WIDTH-1:0]               = entry;
      return w;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ply_q   <= '0;
         len_q   <= '0;
         ctrl_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ctrl_q <= '0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  len_q   <= len_d;
                  ply_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= (len_d != '0) ? LOAD : FILL;
               end
            end
            LOAD: begin
               if (bus.uci_valid) begin
                  ctrl_q <= ctrl_word(1'b1, ply_q[MAX_DEPTH_LOG2-1:0], bus.uci_in);
                  ply_q  <= ply_d;
                  if (ply_d == len_q) begin
                     state_q <= (len_q < MAX_CNT) ? FILL : DONE;
                  end
               end
            end
            FILL: begin
               ctrl_q <= ctrl_word(1'b0, ply_q[MAX_DEPTH_LOG2-1:0], '0);
               ply_q  <= ply_d;
               if (ply_q == LAST_PLY) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle still shows the last strobe; the pulse follows it.
               if (!done_q) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.uci_ready   = (state_q == LOAD);
   assign bus.pv_ctrl_out = ctrl_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule
